// File: rtl/core_pkg.sv
// core_pkg: shared state encoding and default datapath width for the stream mux family
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority arbiter over N requesters
// Ports: req (request vector), ptr (last winner), fixed (scan from 0 instead of ptr+1),
//        grant (winning index), any_grant (at least one request present).
module rr_arbiter #(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             fixed,
    output logic [SEL_W-1:0] grant,
    output logic             any_grant
);

    // One spare bit so start + offset never overflows before the modulo fold.
    localparam int PW = SEL_W + 1;

    logic [PW-1:0]  start;
    logic [PW-1:0]  off;
    logic [PW-1:0]  sum;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    always_comb begin
        start     = (fixed || PW'(ptr) >= PW'(N - 1)) ? '0 : PW'(ptr) + PW'(1);
        // Rotate by shifting a doubled copy: the wrapped requesters land above the originals.
        dbl       = {req, req} >> start;
        rot       = dbl[N-1:0];
        off       = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
        sum       = start + off;
        grant     = SEL_W'(sum >= PW'(N) ? sum - PW'(N) : sum);
        any_grant = |req;
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel stream mux with round-robin arbitration, packet locking and registered output
// Ports: in_valid/in_ready/in_data/in_last per channel (channel i data at [i*WIDTH +: WIDTH]);
//        out_valid/out_ready/out_data/out_last registered output beat; out_sel = source channel.
module rr_stream_mux
    import core_pkg::*;
#(
    parameter int WIDTH      = XLEN,
    parameter int CHANNELS   = 8,
    parameter int SEL_W      = $clog2(CHANNELS),
    parameter int FIXED_PRIO = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_sel
);

    state_t           state, state_n;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_n;
    logic [SEL_W-1:0] lock_ch, lock_ch_n;
    logic [SEL_W-1:0] arb_grant, grant;
    logic             arb_any, slot_free, xfer, beat_last;
    logic [WIDTH-1:0] beat_data;

    rr_arbiter #(
        .N     (CHANNELS),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .fixed     (FIXED_PRIO != 0),
        .grant     (arb_grant),
        .any_grant (arb_any)
    );

    always_comb begin
        slot_free = !out_valid || out_ready;
        // While locked only the packet owner may move; everyone else is ignored.
        grant     = state == ST_LOCKED ? lock_ch : arb_grant;
        xfer      = slot_free && (state == ST_LOCKED ? in_valid[lock_ch] : arb_any);
        in_ready  = xfer ? CHANNELS'(1) << grant : '0;
        beat_data = in_data[grant*WIDTH +: WIDTH];
        beat_last = in_last[grant];
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        lock_ch_n = lock_ch;
        if (xfer && beat_last) begin
            state_n  = ST_IDLE;
            rr_ptr_n = grant;
        end else if (xfer) begin
            state_n   = ST_LOCKED;
            lock_ch_n = grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= SEL_W'(CHANNELS - 1);
            lock_ch <= '0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_ptr_n;
            lock_ch <= lock_ch_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_last  <= beat_last;
            out_sel   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: randomized scoreboard bench for rr_stream_mux plus fixed-priority and 3-channel checks
module tb_rr_stream_mux;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]   in_valid = '0, in_last = '0, in_ready;
    logic [255:0] in_data = '0;
    logic         out_ready = 1'b0, out_valid, out_last;
    logic [31:0]  out_data;
    logic [2:0]   out_sel;

    rr_stream_mux dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sel(out_sel)
    );

    logic [7:0]   v1 = '0, l1 = '0, ir1;
    logic [255:0] d1 = '0;
    logic         r1 = 1'b0, ov1, ol1;
    logic [31:0]  od1;
    logic [2:0]   os1;

    rr_stream_mux #(.FIXED_PRIO(1)) dut_fix (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1), .in_data(d1),
        .in_last(l1), .out_valid(ov1), .out_ready(r1), .out_data(od1),
        .out_last(ol1), .out_sel(os1)
    );

    logic [2:0]  v2 = '0, l2 = '0, ir2;
    logic [23:0] d2 = '0;
    logic        r2 = 1'b0, ov2, ol2;
    logic [7:0]  od2;
    logic [1:0]  os2;

    rr_stream_mux #(.CHANNELS(3), .WIDTH(8)) dut_3 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(ir2), .in_data(d2),
        .in_last(l2), .out_valid(ov2), .out_ready(r2), .out_data(od2),
        .out_last(ol2), .out_sel(os2)
    );

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [2:0]  s;
    } beat_t;

    beat_t q[$];
    beat_t mb;

    // Reference model state: last winner, packet owner, and whether the output slot is occupied.
    int m_ptr = 7;
    bit m_locked = 0;
    int m_lock = 0;
    bit m_oval = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 7;
        m_locked = 0;
        m_lock = 0;
        m_oval = 0;
    endtask

    // One clock of stimulus on the main DUT; a nonzero dv forces every channel's data to dv.
    task automatic cyc(input logic [7:0] v, input logic [7:0] l, input bit rdy,
                       input logic [31:0] dv = '0);
        int c;
        logic [7:0] exp_rdy;
        @(posedge clk);
        #1;
        in_valid = v;
        in_last = l;
        out_ready = rdy;
        for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = (dv != 0) ? dv : $urandom;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_oval});
        exp_rdy = '0;
        c = -1;
        if (!m_oval || rdy) begin
            if (m_locked) begin
                if (v[m_lock]) c = m_lock;
            end else begin
                for (int k = 1; k <= 8; k++)
                    if (c < 0 && v[(m_ptr + k) % 8]) c = (m_ptr + k) % 8;
            end
            if (c >= 0) begin
                exp_rdy[c] = 1'b1;
                q.push_back('{in_data[c*32 +: 32], l[c], 3'(c)});
                m_oval = 1;
                if (l[c]) begin
                    m_locked = 0;
                    m_ptr = c;
                end else begin
                    m_locked = 1;
                    m_lock = c;
                end
            end else begin
                m_oval = 0;
            end
        end
        #1;
        chk("in_ready", {24'b0, in_ready}, {24'b0, exp_rdy});
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got sel %0d data %0h expected none", out_sel, out_data);
            end else begin
                mb = q.pop_front();
                chk("out_data", out_data, mb.d);
                chk("out_last", {31'b0, out_last}, {31'b0, mb.l});
                chk("out_sel", {29'b0, out_sel}, {29'b0, mb.s});
            end
        end
    end

    initial begin
        #1;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", {31'b0, out_last}, 0);
        chk("rst_sel", {29'b0, out_sel}, 0);
        chk("rst_ready", {24'b0, in_ready}, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Fixed priority: ch3 always beats ch6.
        @(posedge clk);
        #1;
        v1 = 8'h48; l1 = 8'hFF; r1 = 1'b1;
        for (int i = 0; i < 8; i++) d1[i*32 +: 32] = 32'h100 + i;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            chk("fix_ready", {24'b0, ir1}, 32'h08);
            chk("fix_valid", {31'b0, ov1}, 1);
            chk("fix_sel", {29'b0, os1}, 3);
            chk("fix_data", od1, 32'h103);
        end
        v1 = '0;

        // Three channels: pointer lands on 2, then ch0 must win by wrapping.
        d2 = {8'h33, 8'h22, 8'h11};
        l2 = 3'b111; r2 = 1'b1; v2 = 3'b100;
        #1;
        chk("c3_first_ready", {29'b0, ir2}, 32'h4);
        @(posedge clk);
        #1;
        v2 = 3'b101;
        #1;
        chk("c3_wrap_ready", {29'b0, ir2}, 32'h1);
        @(posedge clk);
        #2;
        v2 = '0;
        chk("c3_wrap_valid", {31'b0, ov2}, 1);
        chk("c3_wrap_sel", {30'b0, os2}, 0);
        chk("c3_wrap_data", {24'b0, od2}, 32'h11);

        // All channels valid, single-beat packets: per-beat round robin 0..7,0,1.
        for (int i = 0; i < 10; i++) cyc(8'hFF, 8'hFF, 1);
        cyc(8'h00, 8'hFF, 1);
        cyc(8'h00, 8'hFF, 1);

        // Put the pointer on ch1, then ch2 sends a 3-beat packet while ch5 waits.
        cyc(8'h02, 8'hFF, 1);
        cyc(8'h24, 8'h20, 1, 32'hA1);
        cyc(8'h24, 8'h20, 1, 32'hA2);
        cyc(8'h24, 8'h24, 1, 32'hA3);
        cyc(8'h20, 8'h20, 1, 32'hB5);
        cyc(8'h00, 8'hFF, 1);

        // Consumer stall: output holds, nobody is accepted, then no bubble on release.
        cyc(8'h02, 8'hFF, 1, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            cyc(8'h02, 8'hFF, 0, 32'hDEADBEEF);
            chk("stall_data", out_data, 32'hDEADBEEF);
        end
        cyc(8'h02, 8'hFF, 1, 32'h0BADF00D);
        cyc(8'h02, 8'hFF, 1, 32'h0BADF00D);
        cyc(8'h00, 8'hFF, 1);

        // Random traffic with random packets, valids and backpressure.
        for (int i = 0; i < 600; i++)
            cyc(8'($urandom), 8'($urandom_range(0, 3) == 0 ? 8'h00 : $urandom), $urandom_range(0, 3) != 0);

        // Async reset while ch4 holds a lock.
        cyc(8'h10, 8'h00, 1);
        cyc(8'h10, 8'h00, 1);
        #1;
        reset = 1'b1;
        in_valid = '0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 0);
        chk("async_rst_ready", {24'b0, in_ready}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        cyc(8'h11, 8'hFF, 1);
        cyc(8'h11, 8'hFF, 1);

        for (int i = 0; i < 300; i++)
            cyc(8'($urandom), 8'($urandom), $urandom_range(0, 4) != 0);

        begin
            int budget;
            budget = 0;
            while (q.size() != 0 && budget < 50) begin
                cyc(8'h00, 8'hFF, 1);
                budget++;
            end
            if (q.size() != 0) begin
                compared++;
                mismatched++;
                $display("FAIL drain: got %0d beats pending expected 0", q.size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
